// File: rtl/lsq_pkg.sv
// Shared load/store-queue types and pointer helpers.
package lsq_pkg;

   // Drain path state: idle, or holding a write request to memory.
   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } drain_state_e;

   // Per-entry status flags; width-independent part of a store-queue entry.
   typedef struct packed {
      logic vld;
      logic addr_vld;
      logic cmt;
   } sq_flags_t;

   // Slot index of a wrap-bit pointer (depth is a power of two).
   function automatic logic [31:0] ptr_idx(input logic [31:0] p, input int unsigned depth);
      return p & (depth - 32'd1);
   endfunction

   // True when p lies in [head, lim) on a ptr_w-bit wrapping pointer ring.
   function automatic logic ptr_older(input logic [31:0] p, input logic [31:0] head,
                                      input logic [31:0] lim, input int unsigned ptr_w);
      logic [31:0] mask;
      mask = (32'd1 << ptr_w) - 32'd1;
      return ((p - head) & mask) < ((lim - head) & mask);
   endfunction

endpackage

// File: rtl/sq_fwd_select.sv
// Age-ordered forwarding search: youngest decisive older entry wins.
module sq_fwd_select #(
   parameter  int DEPTH  = 8,
   parameter  int ADDR_W = 16,
   localparam int PTR_W  = $clog2(DEPTH) + 1,
   localparam int IW     = PTR_W - 1
) (
   input  logic [DEPTH-1:0]             vld_i,
   input  logic [DEPTH-1:0]             av_i,
   input  logic [DEPTH-1:0][ADDR_W-1:0] addr_i,
   input  logic [IW-1:0]                head_idx_i,
   input  logic [PTR_W-1:0]             lim_i,
   input  logic [ADDR_W-1:0]            ld_addr_i,
   output logic                         hit_o,
   output logic                         stall_o,
   output logic [IW-1:0]                slot_o
);

   logic [IW-1:0] slot;

   // Walk oldest to youngest so the youngest unresolved-or-matching entry overrides older ones.
   always_comb begin
      hit_o   = 1'b0;
      stall_o = 1'b0;
      slot_o  = '0;
      slot    = '0;
      for (int unsigned a = 0; a < DEPTH; a++) begin
         slot = head_idx_i + IW'(a);
         if ((PTR_W'(a) < lim_i) && vld_i[slot]) begin
            if (!av_i[slot]) begin
               stall_o = 1'b1;
               hit_o   = 1'b0;
            end else if (addr_i[slot] == ld_addr_i) begin
               hit_o   = 1'b1;
               stall_o = 1'b0;
               slot_o  = slot;
            end
         end
      end
   end

endmodule

// File: rtl/store_fwd_queue.sv
// Store queue: in-order alloc, tag-matched execute, commit, drain to memory,
// store-to-load forwarding and flush to a tail snapshot.
module store_fwd_queue
   import lsq_pkg::*;
#(
   parameter  int DEPTH  = 8,
   parameter  int ADDR_W = 16,
   parameter  int DATA_W = 16,
   parameter  int IDX_W  = 6,
   localparam int PTR_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_vld,
   input  logic [IDX_W-1:0]  alloc_idx,
   output logic              alloc_rdy,
   output logic [PTR_W-1:0]  tail_ptr,
   output logic [PTR_W-1:0]  count,
   input  logic              exe_vld,
   input  logic [IDX_W-1:0]  exe_idx,
   input  logic [ADDR_W-1:0] exe_addr,
   input  logic [DATA_W-1:0] exe_data,
   input  logic              ld_vld,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [PTR_W-1:0]  ld_tail,
   output logic              fwd_vld,
   output logic              fwd_hit,
   output logic              fwd_stall,
   output logic [DATA_W-1:0] fwd_data,
   input  logic              cmmt_str,
   input  logic              flsh,
   input  logic [PTR_W-1:0]  flsh_tail,
   output logic              mem_wrt_vld,
   output logic [ADDR_W-1:0] mem_wrt_addr,
   output logic [DATA_W-1:0] mem_wrt_data,
   input  logic              mem_wrt_rdy
);

   localparam int IW = PTR_W - 1;

   typedef struct packed {
      sq_flags_t         f;
      logic [IDX_W-1:0]  idx;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } sq_entry_t;

   sq_entry_t         ent_q [DEPTH];
   logic [PTR_W-1:0]  head_q, cmt_q, tail_q;
   drain_state_e      drn_q;
   logic              mem_vld_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_data_q;
   logic              fwd_vld_q, fwd_hit_q, fwd_stall_q;
   logic [DATA_W-1:0] fwd_data_q;

   logic [PTR_W-1:0]  occ, head_nxt, lim, slot_ptr;
   logic [IW-1:0]     head_idx, head_nxt_idx, cmt_idx, tail_idx, age;
   logic              full, alloc_acc, cmt_ok;
   logic [DEPTH-1:0]  vld_vec, av_vec, kill;
   logic [DEPTH-1:0][ADDR_W-1:0] addr_vec;
   logic              sel_hit, sel_stall;
   logic [IW-1:0]     sel_slot;

   // Pointer arithmetic, handshakes and flush kill mask from registered state.
   always_comb begin
      occ          = tail_q - head_q;
      full         = (occ == PTR_W'(DEPTH));
      head_nxt     = head_q + PTR_W'(1);
      head_idx     = IW'(ptr_idx(32'(head_q), DEPTH));
      head_nxt_idx = IW'(ptr_idx(32'(head_nxt), DEPTH));
      cmt_idx      = IW'(ptr_idx(32'(cmt_q), DEPTH));
      tail_idx     = IW'(ptr_idx(32'(tail_q), DEPTH));
      alloc_acc    = alloc_vld && !full && !flsh;
      cmt_ok       = cmmt_str && (cmt_q != tail_q) && ent_q[cmt_idx].f.addr_vld;
      lim          = ld_tail - head_q;
      age          = '0;
      slot_ptr     = '0;
      kill         = '0;
      vld_vec      = '0;
      av_vec       = '0;
      addr_vec     = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         vld_vec[i]  = ent_q[i].f.vld;
         av_vec[i]   = ent_q[i].f.addr_vld;
         addr_vec[i] = ent_q[i].addr;
         // Recover the full wrap-bit pointer of slot i from its age relative to head.
         age         = IW'(i) - head_idx;
         slot_ptr    = head_q + PTR_W'(age);
         kill[i]     = flsh
                    && ptr_older(32'(slot_ptr), 32'(head_q), 32'(tail_q), PTR_W)
                    && !ptr_older(32'(slot_ptr), 32'(head_q), 32'(flsh_tail), PTR_W);
      end
   end

   sq_fwd_select #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) u_sel (
      .vld_i     (vld_vec),
      .av_i      (av_vec),
      .addr_i    (addr_vec),
      .head_idx_i(head_idx),
      .lim_i     (lim),
      .ld_addr_i (ld_addr),
      .hit_o     (sel_hit),
      .stall_o   (sel_stall),
      .slot_o    (sel_slot)
   );

   // Entry array, pointers, drain FSM and registered forward response.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         head_q      <= '0;
         cmt_q       <= '0;
         tail_q      <= '0;
         drn_q       <= IDLE;
         mem_vld_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         fwd_vld_q   <= 1'b0;
         fwd_hit_q   <= 1'b0;
         fwd_stall_q <= 1'b0;
         fwd_data_q  <= '0;
      end else begin
         if (alloc_acc) begin
            ent_q[tail_idx].f   <= '{vld: 1'b1, addr_vld: 1'b0, cmt: 1'b0};
            ent_q[tail_idx].idx <= alloc_idx;
         end
         tail_q <= flsh ? flsh_tail : tail_q + PTR_W'(alloc_acc);

         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (exe_vld && ent_q[i].f.vld && (ent_q[i].idx == exe_idx)) begin
               ent_q[i].addr       <= exe_addr;
               ent_q[i].data       <= exe_data;
               ent_q[i].f.addr_vld <= 1'b1;
            end
         end

         if (cmt_ok) begin
            cmt_q               <= cmt_q + PTR_W'(1);
            ent_q[cmt_idx].f.cmt <= 1'b1;
         end

         case (drn_q)
            IDLE: begin
               if (head_q != cmt_q) begin
                  drn_q      <= WRITE;
                  mem_vld_q  <= 1'b1;
                  mem_addr_q <= ent_q[head_idx].addr;
                  mem_data_q <= ent_q[head_idx].data;
               end
            end
            WRITE: begin
               if (mem_wrt_rdy) begin
                  ent_q[head_idx].f.vld <= 1'b0;
                  head_q                <= head_nxt;
                  if (head_nxt != cmt_q) begin
                     mem_addr_q <= ent_q[head_nxt_idx].addr;
                     mem_data_q <= ent_q[head_nxt_idx].data;
                  end else begin
                     drn_q      <= IDLE;
                     mem_vld_q  <= 1'b0;
                     mem_addr_q <= '0;
                     mem_data_q <= '0;
                  end
               end
            end
            default: drn_q <= IDLE;
         endcase

         // Placed after execute so a flush overrides a same-cycle execute to a flushed slot.
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (kill[i]) begin
               ent_q[i].f.vld      <= 1'b0;
               ent_q[i].f.addr_vld <= 1'b0;
            end
         end

         fwd_vld_q   <= ld_vld;
         fwd_hit_q   <= ld_vld && sel_hit;
         fwd_stall_q <= ld_vld && sel_stall;
         fwd_data_q  <= (ld_vld && sel_hit) ? ent_q[sel_slot].data : '0;
      end
   end

   assign alloc_rdy    = !full && !flsh;
   assign tail_ptr     = tail_q;
   assign count        = occ;
   assign fwd_vld      = fwd_vld_q;
   assign fwd_hit      = fwd_hit_q;
   assign fwd_stall    = fwd_stall_q;
   assign fwd_data     = fwd_data_q;
   assign mem_wrt_vld  = mem_vld_q;
   assign mem_wrt_addr = mem_addr_q;
   assign mem_wrt_data = mem_data_q;

endmodule

// File: tb/tb_store_fwd_queue.sv
// Directed bench for store_fwd_queue (DEPTH=8, 16-bit addr/data, 6-bit tags).
module tb_store_fwd_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        alloc_vld;
   logic [5:0]  alloc_idx;
   logic        alloc_rdy;
   logic [3:0]  tail_ptr;
   logic [3:0]  count;
   logic        exe_vld;
   logic [5:0]  exe_idx;
   logic [15:0] exe_addr;
   logic [15:0] exe_data;
   logic        ld_vld;
   logic [15:0] ld_addr;
   logic [3:0]  ld_tail;
   logic        fwd_vld, fwd_hit, fwd_stall;
   logic [15:0] fwd_data;
   logic        cmmt_str;
   logic        flsh;
   logic [3:0]  flsh_tail;
   logic        mem_wrt_vld;
   logic [15:0] mem_wrt_addr;
   logic [15:0] mem_wrt_data;
   logic        mem_wrt_rdy;

   int errors = 0;
   int checks = 0;

   store_fwd_queue #(
      .DEPTH (8),
      .ADDR_W(16),
      .DATA_W(16),
      .IDX_W (6)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .alloc_vld   (alloc_vld),
      .alloc_idx   (alloc_idx),
      .alloc_rdy   (alloc_rdy),
      .tail_ptr    (tail_ptr),
      .count       (count),
      .exe_vld     (exe_vld),
      .exe_idx     (exe_idx),
      .exe_addr    (exe_addr),
      .exe_data    (exe_data),
      .ld_vld      (ld_vld),
      .ld_addr     (ld_addr),
      .ld_tail     (ld_tail),
      .fwd_vld     (fwd_vld),
      .fwd_hit     (fwd_hit),
      .fwd_stall   (fwd_stall),
      .fwd_data    (fwd_data),
      .cmmt_str    (cmmt_str),
      .flsh        (flsh),
      .flsh_tail   (flsh_tail),
      .mem_wrt_vld (mem_wrt_vld),
      .mem_wrt_addr(mem_wrt_addr),
      .mem_wrt_data(mem_wrt_data),
      .mem_wrt_rdy (mem_wrt_rdy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alloc_vld = 1'b0; alloc_idx = '0;
      exe_vld = 1'b0; exe_idx = '0; exe_addr = '0; exe_data = '0;
      ld_vld = 1'b0; ld_addr = '0; ld_tail = '0;
      cmmt_str = 1'b0; flsh = 1'b0; flsh_tail = '0;
      mem_wrt_rdy = 1'b0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst = 1'b0;
      tick(); tick();
      rst = 1'b1;
   endtask

   task automatic do_alloc(input logic [5:0] idx);
      alloc_vld = 1'b1; alloc_idx = idx;
      tick();
      alloc_vld = 1'b0;
   endtask

   task automatic do_exe(input logic [5:0] idx, input logic [15:0] a, input logic [15:0] d);
      exe_vld = 1'b1; exe_idx = idx; exe_addr = a; exe_data = d;
      tick();
      exe_vld = 1'b0;
   endtask

   task automatic do_query(input logic [15:0] a, input logic [3:0] t);
      ld_vld = 1'b1; ld_addr = a; ld_tail = t;
      tick();
      ld_vld = 1'b0;
   endtask

   task automatic do_commit();
      cmmt_str = 1'b1;
      tick();
      cmmt_str = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      tick(); tick();
      checks++; if (alloc_rdy !== 1'b1) begin errors++; $display("FAIL reset_alloc_rdy: got %0h exp 1", alloc_rdy); end
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
      checks++; if (mem_wrt_vld !== 1'b0) begin errors++; $display("FAIL reset_mem_vld: got %0h exp 0", mem_wrt_vld); end
      checks++; if (fwd_vld !== 1'b0) begin errors++; $display("FAIL reset_fwd_vld: got %0h exp 0", fwd_vld); end
      checks++; if (tail_ptr !== 4'd0) begin errors++; $display("FAIL reset_tail: got %0d exp 0", tail_ptr); end
      rst = 1'b1;
   endtask

   task automatic test_single_forward();
      apply_reset();
      do_alloc(6'd2);
      do_exe(6'd2, 16'h0000, 16'haaaa);
      do_query(16'h0000, 4'd1);
      checks++; if (fwd_vld !== 1'b1) begin errors++; $display("FAIL t2_fwd_vld: got %0h exp 1", fwd_vld); end
      checks++; if (fwd_hit !== 1'b1) begin errors++; $display("FAIL t2_hit: got %0h exp 1", fwd_hit); end
      checks++; if (fwd_data !== 16'haaaa) begin errors++; $display("FAIL t2_data: got %h exp aaaa", fwd_data); end
      do_query(16'h0001, 4'd1);
      checks++; if ({fwd_vld, fwd_hit, fwd_stall} !== 3'b100) begin errors++; $display("FAIL t2_miss: got %b exp 100", {fwd_vld, fwd_hit, fwd_stall}); end
      tick();
      checks++; if ({fwd_vld, fwd_hit, fwd_stall} !== 3'b000) begin errors++; $display("FAIL t2_no_query: got %b exp 000", {fwd_vld, fwd_hit, fwd_stall}); end
   endtask

   task automatic test_age_order();
      apply_reset();
      do_alloc(6'd4);
      do_alloc(6'd5);
      do_exe(6'd4, 16'h0001, 16'hbbbb);
      do_exe(6'd5, 16'h0001, 16'hcccc);
      do_query(16'h0001, 4'd2);
      checks++; if (fwd_hit !== 1'b1 || fwd_data !== 16'hcccc) begin errors++; $display("FAIL t3_youngest: got hit=%0h data=%h exp hit=1 data=cccc", fwd_hit, fwd_data); end
      do_query(16'h0001, 4'd1);
      checks++; if (fwd_hit !== 1'b1 || fwd_data !== 16'hbbbb) begin errors++; $display("FAIL t3_older_only: got hit=%0h data=%h exp hit=1 data=bbbb", fwd_hit, fwd_data); end
      do_alloc(6'd6);
      do_query(16'h0001, 4'd3);
      checks++; if ({fwd_hit, fwd_stall} !== 2'b01) begin errors++; $display("FAIL t3_stall: got hit/stall=%b exp 01", {fwd_hit, fwd_stall}); end
      // Execute and query in the same cycle: the query sees the unresolved address.
      exe_vld = 1'b1; exe_idx = 6'd6; exe_addr = 16'h0001; exe_data = 16'hdddd;
      ld_vld = 1'b1; ld_addr = 16'h0001; ld_tail = 4'd3;
      tick();
      exe_vld = 1'b0; ld_vld = 1'b0;
      checks++; if ({fwd_hit, fwd_stall} !== 2'b01) begin errors++; $display("FAIL t3_same_cycle: got hit/stall=%b exp 01", {fwd_hit, fwd_stall}); end
      do_query(16'h0001, 4'd3);
      checks++; if (fwd_hit !== 1'b1 || fwd_data !== 16'hdddd) begin errors++; $display("FAIL t3_after_exe: got hit=%0h data=%h exp hit=1 data=dddd", fwd_hit, fwd_data); end
   endtask

   task automatic test_full_drain_wrap();
      apply_reset();
      alloc_vld = 1'b1;
      for (int i = 0; i < 8; i++) begin
         alloc_idx = 6'(i);
         tick();
      end
      checks++; if (alloc_rdy !== 1'b0) begin errors++; $display("FAIL t4_full_rdy: got %0h exp 0", alloc_rdy); end
      checks++; if (count !== 4'd8) begin errors++; $display("FAIL t4_full_count: got %0d exp 8", count); end
      alloc_idx = 6'd9;
      tick();
      alloc_vld = 1'b0;
      checks++; if (count !== 4'd8 || tail_ptr !== 4'd8) begin errors++; $display("FAIL t4_alloc_when_full: got count=%0d tail=%0d exp 8/8", count, tail_ptr); end
      for (int i = 0; i < 8; i++) do_exe(6'(i), 16'(16 + i), 16'(16'h1000 + i));
      cmmt_str = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      cmmt_str = 1'b0;
      checks++; if (mem_wrt_vld !== 1'b1 || mem_wrt_addr !== 16'd16 || mem_wrt_data !== 16'h1000) begin errors++; $display("FAIL t4_first_write: got vld=%0h addr=%h data=%h exp 1/0010/1000", mem_wrt_vld, mem_wrt_addr, mem_wrt_data); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (mem_wrt_vld !== 1'b1 || mem_wrt_addr !== 16'd16 || mem_wrt_data !== 16'h1000 || count !== 4'd8) begin errors++; $display("FAIL t4_hold_%0d: got vld=%0h addr=%h data=%h count=%0d exp 1/0010/1000/8", i, mem_wrt_vld, mem_wrt_addr, mem_wrt_data, count); end
      end
      mem_wrt_rdy = 1'b1;
      tick();
      checks++; if (count !== 4'd7 || alloc_rdy !== 1'b1) begin errors++; $display("FAIL t4_first_drain: got count=%0d rdy=%0h exp 7/1", count, alloc_rdy); end
      checks++; if (mem_wrt_vld !== 1'b1 || mem_wrt_addr !== 16'd17 || mem_wrt_data !== 16'h1001) begin errors++; $display("FAIL t4_b2b: got vld=%0h addr=%h data=%h exp 1/0011/1001", mem_wrt_vld, mem_wrt_addr, mem_wrt_data); end
      for (int k = 1; k < 8; k++) begin
         tick();
         if (k < 7) begin
            checks++; if (mem_wrt_vld !== 1'b1 || mem_wrt_addr !== 16'(17 + k)) begin errors++; $display("FAIL t4_drain_%0d: got vld=%0h addr=%h exp 1/%h", k, mem_wrt_vld, mem_wrt_addr, 16'(17 + k)); end
         end
      end
      checks++; if (mem_wrt_vld !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL t4_empty: got vld=%0h count=%0d exp 0/0", mem_wrt_vld, count); end
      for (int k = 0; k < 16; k++) begin
         do_alloc(6'(k));
         checks++; if (tail_ptr !== 4'(9 + k) || count !== 4'd1) begin errors++; $display("FAIL t4_wrap_alloc_%0d: got tail=%0d count=%0d exp %0d/1", k, tail_ptr, count, 4'(9 + k)); end
         do_exe(6'(k), 16'(32 + k), 16'(16'h2000 + k));
         do_query(16'(32 + k), 4'(9 + k));
         checks++; if (fwd_hit !== 1'b1 || fwd_data !== 16'(16'h2000 + k)) begin errors++; $display("FAIL t4_wrap_fwd_%0d: got hit=%0h data=%h exp 1/%h", k, fwd_hit, fwd_data, 16'(16'h2000 + k)); end
         do_commit();
         tick();
         checks++; if (mem_wrt_vld !== 1'b1 || mem_wrt_addr !== 16'(32 + k)) begin errors++; $display("FAIL t4_wrap_write_%0d: got vld=%0h addr=%h exp 1/%h", k, mem_wrt_vld, mem_wrt_addr, 16'(32 + k)); end
         tick();
         checks++; if (mem_wrt_vld !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL t4_wrap_done_%0d: got vld=%0h count=%0d exp 0/0", k, mem_wrt_vld, count); end
      end
      mem_wrt_rdy = 1'b0;
   endtask

   task automatic test_flush();
      apply_reset();
      do_alloc(6'd10);
      do_alloc(6'd11);
      do_alloc(6'd12);
      do_alloc(6'd13);
      do_exe(6'd10, 16'h0005, 16'h5555);
      do_exe(6'd11, 16'h0006, 16'h6666);
      do_exe(6'd12, 16'h0007, 16'h7777);
      do_exe(6'd13, 16'h0007, 16'h8888);
      do_commit();
      flsh = 1'b1; flsh_tail = 4'd2;
      alloc_vld = 1'b1; alloc_idx = 6'd20;
      #1;
      checks++; if (alloc_rdy !== 1'b0) begin errors++; $display("FAIL t5_rdy_during_flush: got %0h exp 0", alloc_rdy); end
      tick();
      flsh = 1'b0; alloc_vld = 1'b0;
      checks++; if (tail_ptr !== 4'd2 || count !== 4'd2) begin errors++; $display("FAIL t5_tail_count: got tail=%0d count=%0d exp 2/2", tail_ptr, count); end
      do_query(16'h0007, 4'd4);
      checks++; if ({fwd_vld, fwd_hit, fwd_stall} !== 3'b100) begin errors++; $display("FAIL t5_flushed_miss: got %b exp 100", {fwd_vld, fwd_hit, fwd_stall}); end
      do_query(16'h0006, 4'd4);
      checks++; if (fwd_hit !== 1'b1 || fwd_data !== 16'h6666) begin errors++; $display("FAIL t5_kept_hit: got hit=%0h data=%h exp 1/6666", fwd_hit, fwd_data); end
      do_exe(6'd20, 16'h0007, 16'h9999);
      do_exe(6'd12, 16'h0007, 16'h9999);
      do_query(16'h0007, 4'd4);
      checks++; if ({fwd_hit, fwd_stall} !== 2'b00 || tail_ptr !== 4'd2) begin errors++; $display("FAIL t5_dropped_alloc: got hit/stall=%b tail=%0d exp 00/2", {fwd_hit, fwd_stall}, tail_ptr); end
   endtask

   task automatic test_reset_mid_drain();
      apply_reset();
      do_alloc(6'd30);
      do_exe(6'd30, 16'h0009, 16'h1234);
      do_commit();
      tick();
      checks++; if (mem_wrt_vld !== 1'b1 || mem_wrt_addr !== 16'h0009) begin errors++; $display("FAIL t6_pending: got vld=%0h addr=%h exp 1/0009", mem_wrt_vld, mem_wrt_addr); end
      rst = 1'b0;
      tick();
      checks++; if (mem_wrt_vld !== 1'b0 || count !== 4'd0 || tail_ptr !== 4'd0) begin errors++; $display("FAIL t6_reset: got vld=%0h count=%0d tail=%0d exp 0/0/0", mem_wrt_vld, count, tail_ptr); end
      rst = 1'b1;
      mem_wrt_rdy = 1'b1;
      tick(); tick(); tick();
      checks++; if (mem_wrt_vld !== 1'b0 || alloc_rdy !== 1'b1) begin errors++; $display("FAIL t6_dropped: got vld=%0h rdy=%0h exp 0/1", mem_wrt_vld, alloc_rdy); end
      mem_wrt_rdy = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b0;
      test_reset();
      test_single_forward();
      test_age_order();
      test_full_drain_wrap();
      test_flush();
      test_reset_mid_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
